// File: rtl/serial_subtractor.sv
// Purpose: bit-serial unsigned subtractor, out = (data_a - data_b) mod 2^WIDTH, LSB first.
// Latency: start accepted at edge E0; out/bout/done valid after edge E(WIDTH); one op per WIDTH+2 cycles.
// Backpressure: none; start is only honoured in IDLE and is dropped (not queued) while busy/done.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset, dominates everything
//   start         request, sampled only in IDLE
//   data_a/data_b minuend/subtrahend, captured on the accepting edge only
//   out           registered difference, holds until next completion or reset
//   bout          registered final borrow (1 iff data_a < data_b)
//   busy          high while shifting
//   done          one-cycle pulse when out/bout update
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] out,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             bw;

  logic             d;
  logic             bw_next;
  logic             last;
  logic [WIDTH-1:0] sr_next;

  // Full-subtractor cell on the current LSBs with the registered borrow.
  assign d       = sa[0] ^ sb[0] ^ bw;
  assign bw_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bw);
  assign last    = (cnt == CW'(WIDTH - 1));
  // Result enters at the MSB so after WIDTH shifts bit 0 sits in sr[0].
  assign sr_next = {d, sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sa   <= '0;
      sb   <= '0;
      sr   <= '0;
      cnt  <= '0;
      bw   <= 1'b0;
      out  <= '0;
      bout <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa   <= data_a;
            sb   <= data_b;
            sr   <= '0;
            cnt  <= '0;
            bw   <= 1'b0;
            busy <= 1'b1;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= sr_next;
          cnt <= cnt + CW'(1);
          bw  <= bw_next;
          // Publish only the complete result so out/bout never show partial values.
          if (last) begin
            out  <= sr_next;
            bout <= bw_next;
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        DONE: begin
          done <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Purpose: scoreboard bench for serial_subtractor with directed, hand-computed vectors.
// Latency: expects done exactly WIDTH edges after the accepting edge.
// Backpressure: n/a; checks that start is ignored while an operation is in flight.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] data_a;
  logic [W-1:0] data_b;
  logic [W-1:0] out;
  logic         bout;
  logic         busy;
  logic         done;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .data_a (data_a),
    .data_b (data_b),
    .out    (out),
    .bout   (bout),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] out;
    logic         bout;
    int           cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("out", int'(out), int'(e.out));
        chk("bout", int'(bout), int'(e.bout));
        chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  // Drive one start pulse; optionally record the hand-computed result.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_out, input logic exp_b, input bit push);
    exp_t x;
    @(negedge clk);
    data_a = a;
    data_b = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      x.out  = exp_out;
      x.bout = exp_b;
      x.cyc  = cyc + W;
      q.push_back(x);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_out, input logic exp_b);
    issue(a, b, exp_out, exp_b, 1'b1);
    repeat (W + 2) @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_out"}, int'(out), 0);
    chk({tag, "_bout"}, int'(bout), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int busy_cycles;
    int dc;
    reset  = 1'b1;
    start  = 1'b0;
    data_a = '0;
    data_b = '0;
    @(negedge clk);
    @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("idle");

    // Basic subtraction with busy-width and done-count checks.
    dc = done_cnt;
    issue(4'b1100, 4'b1010, 4'b0010, 1'b0, 1'b1);
    busy_cycles = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cycles++;
    end
    chk("busy_cycles", busy_cycles, W);
    chk("basic_done_count", done_cnt - dc, 1);

    // Borrow / wrap-around.
    run_op(4'b1010, 4'b1100, 4'b1110, 1'b1);
    run_op(4'b0000, 4'b0001, 4'b1111, 1'b1);

    // Equal operands, then no borrow at full scale.
    run_op(4'b1010, 4'b1010, 4'b0000, 1'b0);
    run_op(4'b1111, 4'b0000, 4'b1111, 1'b0);

    // Inputs and start changes while busy must be ignored.
    dc = done_cnt;
    issue(4'b1100, 4'b1101, 4'b1111, 1'b1, 1'b1);
    @(negedge clk);
    data_a = '0;
    data_b = '0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (12) @(negedge clk);
    chk("ignored_done_count", done_cnt - dc, 1);

    // Reset mid-operation abandons the op without a done pulse.
    dc = done_cnt;
    issue(4'b1001, 4'b0011, 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle("midop_reset");
    repeat (8) @(negedge clk);
    chk("midop_done_count", done_cnt - dc, 0);
    run_op(4'b1001, 4'b0011, 4'b0110, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor: computes data_a - data_b one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Inverse-operation companion to the team's serial adder; shares its operand/result style.
- Adds a start/busy/done handshake so a controller can sequence operations.
- Sits beside the serial adder in the arithmetic datapath experiments.

Parameters:
- WIDTH, 4, operand and result width in bits (>= 2).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- data_a  input  WIDTH  minuend; captured on the accepting edge only.
- data_b  input  WIDTH  subtrahend; captured on the accepting edge only.
- out  output  WIDTH  registered difference (data_a - data_b) mod 2^WIDTH.
- bout  output  1  registered final borrow; 1 iff data_a < data_b (unsigned).
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when out/bout are updated.

Behaviour:
- Reset (synchronous, active-high, dominates everything): state = IDLE. out, bout, busy and done = 0. Shift registers, bit counter and borrow FF = 0. A reset mid-operation abandons the operation with no done pulse.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - On an edge with start = 1, load data_a and data_b into shift registers sa and sb.
  - Clear the borrow FF, the result shift register sr and the counter.
  - Next state SHIFT; busy = 1.
  - start = 0: remain in IDLE.
- SHIFT, one bit per edge:
  - d = sa[0] ^ sb[0] ^ bw.
  - bw_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bw).
  - sr shifts right with d entering the MSB. sa and sb shift right. Counter increments.
  - On the edge processing bit WIDTH-1 (counter = WIDTH-1):
    - out <= final sr value, including that bit.
    - bout <= bw_next.
    - done <= 1, busy <= 0, next state DONE.
- DONE: lasts one cycle. done returns to 0 on the next edge; state IDLE.
- Latency: start is sampled at edge E0; out, bout and done are valid after edge E(WIDTH). For WIDTH = 4, that is 4 edges after acceptance. Back-to-back throughput is one operation per WIDTH+2 cycles.
- start is ignored in SHIFT and DONE; it is not queued.
- data_a and data_b changes after the accepting edge have no effect.
- out and bout hold their last result until the next completion or reset; they never show partial values.
- Equal operands give out = 0 and bout = 0.
- Wrap-around: the result is modulo 2^WIDTH, with the borrow reported only on bout.

Test Plan:
- Reset then idle: reset = 1 for 2 cycles -> out = 0000, bout = 0, busy = 0, done = 0. With start held 0 these remain unchanged.
- Basic subtraction: a = 1100, b = 1010, start pulse -> done pulses exactly 4 edges after the accepting edge; out = 0010, bout = 0. busy is high for 4 cycles.
- Borrow/wrap: a = 1010, b = 1100 -> out = 1110, bout = 1. Also a = 0000, b = 0001 -> out = 1111, bout = 1.
- Equal operands: a = b = 1010 -> out = 0000, bout = 0. Then a = 1111, b = 0000 -> out = 1111, bout = 0.
- Ignored inputs: start a = 1100, b = 1101. While busy, change a/b to 0000 and re-pulse start. Required: a single done with out = 1111, bout = 1, and no second operation.
- Reset mid-op: start a = 1001, b = 0011, assert reset after 2 SHIFT edges. Required: no done pulse; out = 0000, bout = 0, busy = 0. A following start with a = 1001, b = 0011 yields out = 0110, bout = 0.
